// File: rtl/vdp_sprite_line_scheduler_pkg.sv
// Shared VDP sprite-scheduler definitions: state encoding, hit-list geometry and
// the default active-line count.
package vdp_sprite_line_scheduler_pkg;

    localparam int unsigned ACTIVE_LINES_DEFAULT   = 240;
    localparam int unsigned HIT_LIST_DEPTH_DEFAULT = 256;
    // {bank, index[7:0]}
    localparam int unsigned HIT_ADDR_W             = 9;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRestart  = 2'd1,
        StEvaluate = 2'd2,
        StDone     = 2'd3
    } sched_state_e;

endpackage

// File: rtl/vdp_sprite_line_scheduler.sv
// Sprite line scheduler: restarts the Y-collision evaluator at each line start,
// routes its hit-list writes into the back bank of a ping-pong RAM and swaps banks
// once a list is complete so the renderer always reads a finished list.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   line_start, line_y    one-cycle line pulse and the line to evaluate next
//   eval_restart          evaluator restart, high whenever not evaluating
//   eval_render_y         line handed to the evaluator, stable while evaluating
//   eval_finished         evaluator completion flag
//   eval_write_en/index   evaluator hit-list write strobe and entry index
//   hitlist_wr_en/addr    registered hit-list RAM write port ({bank, index})
//   render_bank           bank the renderer reads
//   render_list_valid     render_bank holds a completed list for this line
//   overrun, overrun_clear sticky late-evaluation flag and its clear
module vdp_sprite_line_scheduler
    import vdp_sprite_line_scheduler_pkg::*;
#(
    parameter int unsigned ACTIVE_LINES   = ACTIVE_LINES_DEFAULT,
    parameter int unsigned HIT_LIST_DEPTH = HIT_LIST_DEPTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  line_start,
    input  logic [8:0]            line_y,
    output logic                  eval_restart,
    output logic [8:0]            eval_render_y,
    input  logic                  eval_finished,
    input  logic                  eval_write_en,
    input  logic [8:0]            eval_index,
    output logic                  hitlist_wr_en,
    output logic [HIT_ADDR_W-1:0] hitlist_wr_addr,
    output logic                  render_bank,
    output logic                  render_list_valid,
    output logic                  overrun,
    input  logic                  overrun_clear
);

    sched_state_e state;
    logic         write_bank;
    logic         line_active;
    logic         list_complete;
    logic         write_ok;

    assign line_active   = 32'(line_y) < ACTIVE_LINES;
    // A finish arriving together with the line start still counts as a complete list.
    assign list_complete = (state == StDone) || (state == StEvaluate && eval_finished);
    assign write_ok      = eval_write_en && (state == StEvaluate || state == StDone) &&
                           (32'(eval_index) < HIT_LIST_DEPTH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= StIdle;
            eval_restart      <= 1'b1;
            eval_render_y     <= '0;
            hitlist_wr_en     <= 1'b0;
            hitlist_wr_addr   <= '0;
            write_bank        <= 1'b0;
            render_bank       <= 1'b1;
            render_list_valid <= 1'b0;
            overrun           <= 1'b0;
        end else begin
            // Uses the pre-swap write_bank even on a swapping edge.
            hitlist_wr_en   <= write_ok;
            hitlist_wr_addr <= {write_bank, eval_index[7:0]};

            if (overrun_clear) begin
                overrun <= 1'b0;
            end

            if (line_start) begin
                if (list_complete) begin
                    render_bank       <= write_bank;
                    write_bank        <= ~write_bank;
                    render_list_valid <= 1'b1;
                end else if (state == StEvaluate) begin
                    // Partial list is dropped; the back bank is simply reused.
                    render_list_valid <= 1'b0;
                    overrun           <= 1'b1;
                end else begin
                    render_list_valid <= 1'b0;
                end

                eval_restart <= 1'b1;
                if (line_active) begin
                    state         <= StRestart;
                    eval_render_y <= line_y;
                end else begin
                    state <= StIdle;
                end
            end else begin
                unique case (state)
                    StIdle: begin
                        eval_restart <= 1'b1;
                    end
                    StRestart: begin
                        state        <= StEvaluate;
                        eval_restart <= 1'b0;
                    end
                    StEvaluate: begin
                        eval_restart <= 1'b0;
                        if (eval_finished) begin
                            state <= StDone;
                        end
                    end
                    StDone: begin
                        eval_restart <= 1'b0;
                    end
                    default: begin
                        state        <= StIdle;
                        eval_restart <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vdp_sprite_line_scheduler.sv
// Table-driven bench for vdp_sprite_line_scheduler. Each row gives one cycle of
// stimulus and the outputs expected just after the following rising edge; hit-list
// writes go through a scoreboard queue filled at drive time and drained one edge later.
module tb_vdp_sprite_line_scheduler;

    localparam logic [8:0] RY_ANY = 9'h1FF;  // eval_render_y not checked on this row

    typedef struct {
        logic       ls;
        logic [8:0] ly;
        logic       fin;
        logic       we;
        logic [8:0] idx;
        logic       clr;
        logic       e_rst;
        logic [8:0] e_ry;
        logic       e_rb;
        logic       e_val;
        logic       e_ovr;
        logic       e_wen;
        logic [8:0] e_wa;
    } vec_t;

    typedef struct {
        logic       en;
        logic [8:0] addr;
    } wr_t;

    logic       clk;
    logic       reset_n;
    logic       line_start;
    logic [8:0] line_y;
    logic       eval_restart;
    logic [8:0] eval_render_y;
    logic       eval_finished;
    logic       eval_write_en;
    logic [8:0] eval_index;
    logic       hitlist_wr_en;
    logic [8:0] hitlist_wr_addr;
    logic       render_bank;
    logic       render_list_valid;
    logic       overrun;
    logic       overrun_clear;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t vecs[$];
    wr_t  sb[$];

    vdp_sprite_line_scheduler dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .line_start        (line_start),
        .line_y            (line_y),
        .eval_restart      (eval_restart),
        .eval_render_y     (eval_render_y),
        .eval_finished     (eval_finished),
        .eval_write_en     (eval_write_en),
        .eval_index        (eval_index),
        .hitlist_wr_en     (hitlist_wr_en),
        .hitlist_wr_addr   (hitlist_wr_addr),
        .render_bank       (render_bank),
        .render_list_valid (render_list_valid),
        .overrun           (overrun),
        .overrun_clear     (overrun_clear)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(logic ls, logic [8:0] ly, logic fin, logic we, logic [8:0] idx,
                                logic clr, logic e_rst, logic [8:0] e_ry, logic e_rb,
                                logic e_val, logic e_ovr, logic e_wen, logic [8:0] e_wa);
        vec_t v;
        v.ls = ls; v.ly = ly; v.fin = fin; v.we = we; v.idx = idx; v.clr = clr;
        v.e_rst = e_rst; v.e_ry = e_ry; v.e_rb = e_rb; v.e_val = e_val; v.e_ovr = e_ovr;
        v.e_wen = e_wen; v.e_wa = e_wa;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, clock it, then compare the post-edge outputs.
    task automatic step(input vec_t v, input int row);
        wr_t w;
        wr_t got;
        line_start    = v.ls;
        line_y        = v.ly;
        eval_finished = v.fin;
        eval_write_en = v.we;
        eval_index    = v.idx;
        overrun_clear = v.clr;
        w.en   = v.e_wen;
        w.addr = v.e_wa;
        sb.push_back(w);
        @(posedge clk);
        #1;
        chk("eval_restart", row, 32'(eval_restart), 32'(v.e_rst));
        if (v.e_ry != RY_ANY) chk("eval_render_y", row, 32'(eval_render_y), 32'(v.e_ry));
        chk("render_bank", row, 32'(render_bank), 32'(v.e_rb));
        chk("render_list_valid", row, 32'(render_list_valid), 32'(v.e_val));
        chk("overrun", row, 32'(overrun), 32'(v.e_ovr));
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard row %0d: queue empty", row);
        end else begin
            got = sb.pop_front();
            chk("hitlist_wr_en", row, 32'(hitlist_wr_en), 32'(got.en));
            if (got.en) chk("hitlist_wr_addr", row, 32'(hitlist_wr_addr), 32'(got.addr));
        end
    endtask

    initial begin
        //           ls ly    fin we idx     clr  rst ry    rb val ovr wen wa
        vecs.push_back(mk(0, 9'd0,   0, 0, 9'h000, 0,  1, 9'd0,  1, 0, 0, 0, 9'h000)); // 0
        vecs.push_back(mk(1, 9'd10,  0, 0, 9'h000, 0,  1, 9'd10, 1, 0, 0, 0, 9'h000)); // 1
        vecs.push_back(mk(0, 9'd0,   0, 0, 9'h000, 0,  0, 9'd10, 1, 0, 0, 0, 9'h000)); // 2
        vecs.push_back(mk(0, 9'd0,   0, 1, 9'h000, 0,  0, 9'd10, 1, 0, 0, 1, 9'h000)); // 3
        vecs.push_back(mk(0, 9'd0,   0, 1, 9'h001, 0,  0, 9'd10, 1, 0, 0, 1, 9'h001)); // 4
        vecs.push_back(mk(0, 9'd0,   0, 1, 9'h002, 0,  0, 9'd10, 1, 0, 0, 1, 9'h002)); // 5
        vecs.push_back(mk(0, 9'd0,   1, 0, 9'h000, 0,  0, 9'd10, 1, 0, 0, 0, 9'h000)); // 6
        vecs.push_back(mk(0, 9'd0,   0, 1, 9'h005, 0,  0, 9'd10, 1, 0, 0, 1, 9'h005)); // 7
        vecs.push_back(mk(1, 9'd11,  0, 0, 9'h000, 0,  1, 9'd11, 0, 1, 0, 0, 9'h000)); // 8
        vecs.push_back(mk(0, 9'd0,   0, 1, 9'h003, 0,  0, 9'd11, 0, 1, 0, 0, 9'h000)); // 9
        vecs.push_back(mk(0, 9'd0,   0, 1, 9'h003, 0,  0, 9'd11, 0, 1, 0, 1, 9'h103)); // 10
        vecs.push_back(mk(0, 9'd0,   0, 1, 9'h100, 0,  0, 9'd11, 0, 1, 0, 0, 9'h000)); // 11
        vecs.push_back(mk(0, 9'd0,   0, 1, 9'h0FF, 0,  0, 9'd11, 0, 1, 0, 1, 9'h1FF)); // 12
        vecs.push_back(mk(1, 9'd12,  0, 1, 9'h004, 0,  1, 9'd12, 0, 0, 1, 1, 9'h104)); // 13
        vecs.push_back(mk(0, 9'd0,   0, 0, 9'h000, 1,  0, 9'd12, 0, 0, 0, 0, 9'h000)); // 14
        vecs.push_back(mk(0, 9'd0,   0, 1, 9'h007, 0,  0, 9'd12, 0, 0, 0, 1, 9'h107)); // 15
        vecs.push_back(mk(1, 9'd13,  1, 1, 9'h008, 0,  1, 9'd13, 1, 1, 0, 1, 9'h108)); // 16
        vecs.push_back(mk(0, 9'd0,   0, 0, 9'h000, 0,  0, 9'd13, 1, 1, 0, 0, 9'h000)); // 17
        vecs.push_back(mk(1, 9'd20,  0, 0, 9'h000, 1,  1, 9'd20, 1, 0, 1, 0, 9'h000)); // 18
        vecs.push_back(mk(0, 9'd0,   0, 0, 9'h000, 1,  0, 9'd20, 1, 0, 0, 0, 9'h000)); // 19
        vecs.push_back(mk(0, 9'd0,   1, 0, 9'h000, 0,  0, 9'd20, 1, 0, 0, 0, 9'h000)); // 20
        vecs.push_back(mk(1, 9'd240, 0, 0, 9'h000, 0,  1, RY_ANY, 0, 1, 0, 0, 9'h000)); // 21
        vecs.push_back(mk(0, 9'd0,   0, 1, 9'h001, 0,  1, RY_ANY, 0, 1, 0, 0, 9'h000)); // 22
        vecs.push_back(mk(0, 9'd0,   1, 0, 9'h000, 0,  1, RY_ANY, 0, 1, 0, 0, 9'h000)); // 23
        vecs.push_back(mk(1, 9'd30,  0, 0, 9'h000, 0,  1, 9'd30, 0, 0, 0, 0, 9'h000)); // 24
        vecs.push_back(mk(0, 9'd0,   0, 0, 9'h000, 0,  0, 9'd30, 0, 0, 0, 0, 9'h000)); // 25
        vecs.push_back(mk(0, 9'd0,   0, 1, 9'h009, 0,  0, 9'd30, 0, 0, 0, 1, 9'h109)); // 26

        reset_n       = 1'b0;
        line_start    = 1'b0;
        line_y        = '0;
        eval_finished = 1'b0;
        eval_write_en = 1'b0;
        eval_index    = '0;
        overrun_clear = 1'b0;
        #12;
        chk("rst eval_restart", -1, 32'(eval_restart), 32'd1);
        chk("rst eval_render_y", -1, 32'(eval_render_y), 32'd0);
        chk("rst hitlist_wr_en", -1, 32'(hitlist_wr_en), 32'd0);
        chk("rst hitlist_wr_addr", -1, 32'(hitlist_wr_addr), 32'd0);
        chk("rst render_bank", -1, 32'(render_bank), 32'd1);
        chk("rst render_list_valid", -1, 32'(render_list_valid), 32'd0);
        chk("rst overrun", -1, 32'(overrun), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], i);
        end

        // Mid-EVALUATE asynchronous reset: outputs must change before any clock edge.
        #3;
        reset_n = 1'b0;
        #1;
        chk("async eval_restart", 100, 32'(eval_restart), 32'd1);
        chk("async eval_render_y", 100, 32'(eval_render_y), 32'd0);
        chk("async hitlist_wr_en", 100, 32'(hitlist_wr_en), 32'd0);
        chk("async hitlist_wr_addr", 100, 32'(hitlist_wr_addr), 32'd0);
        chk("async render_bank", 100, 32'(render_bank), 32'd1);
        chk("async render_list_valid", 100, 32'(render_list_valid), 32'd0);
        chk("async overrun", 100, 32'(overrun), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        sb.delete();

        // After reset the write bank is 0 again.
        step(mk(1, 9'd5, 0, 0, 9'h000, 0, 1, 9'd5, 1, 0, 0, 0, 9'h000), 101);
        step(mk(0, 9'd0, 0, 0, 9'h000, 0, 0, 9'd5, 1, 0, 0, 0, 9'h000), 102);
        step(mk(0, 9'd0, 0, 1, 9'h0AA, 0, 0, 9'd5, 1, 0, 0, 1, 9'h0AA), 103);
        step(mk(0, 9'd0, 0, 0, 9'h000, 0, 0, 9'd5, 1, 0, 0, 0, 9'h000), 104);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vdp_sprite_line_scheduler.md
Name: vdp_sprite_line_scheduler

Overview:
- Sequences the per-line sprite Y-collision evaluator and owns the ping-pong hit-list buffer banks.
- On each line start it restarts the evaluator for the upcoming line and routes the evaluator's hit-list writes into the back bank.
- When evaluation is complete it swaps banks so the sprite renderer reads a finished list.
- Sits between the VDP raster timing generator, the collision evaluator and the hit-list RAM.

Parameters:
- ACTIVE_LINES, 240: lines with y below this are evaluated; lines at or above it get no evaluation (blanking).
- HIT_LIST_DEPTH, 256: entries per bank. Evaluator indices at or above this are dropped.

Ports:
- clk  in  1  VDP clock
- reset_n  in  1  asynchronous active-low reset
- line_start  in  1  one-cycle pulse; next line to evaluate is on line_y
- line_y  in  9  line number to evaluate, sampled on line_start
- eval_restart  out  1  restart to collision evaluator; held high while not evaluating
- eval_render_y  out  9  render_y to collision evaluator, stable during evaluation
- eval_finished  in  1  evaluator finished flag
- eval_write_en  in  1  evaluator hit-list write strobe
- eval_index  in  9  evaluator hit-list index
- hitlist_wr_en  out  1  hit-list RAM write enable
- hitlist_wr_addr  out  9  {write_bank, index[7:0]}
- render_bank  out  1  bank the renderer reads
- render_list_valid  out  1  render_bank holds a completed list for the current line
- overrun  out  1  sticky: a line started before evaluation finished
- overrun_clear  in  1  clears overrun

Behaviour:
- Reset (async, reset_n low) values:
  - state IDLE, eval_restart 1, eval_render_y 0
  - hitlist_wr_en 0, hitlist_wr_addr 0
  - write_bank 0, render_bank 1, render_list_valid 0, overrun 0
- States: IDLE, RESTART, EVALUATE, DONE.
- IDLE:
  - eval_restart=1.
  - On line_start with line_y < ACTIVE_LINES: register eval_render_y<=line_y, go to RESTART.
  - Otherwise stay in IDLE.
- RESTART (exactly 1 cycle): eval_restart=1, then go to EVALUATE. Timing: line_start at cycle T gives eval_restart asserted in T+1 and deasserted from T+2.
- EVALUATE:
  - eval_restart=0.
  - eval_finished=1 → go to DONE.
- DONE: eval_restart=0; hold until line_start.
- line_start handling (highest priority, any state):
  - From DONE: render_bank<=write_bank, write_bank<=~write_bank, render_list_valid<=1.
  - From EVALUATE without eval_finished in the same cycle (overrun):
    - render_list_valid<=0, overrun<=1, banks unchanged.
    - The partial list is discarded; the back bank is reused.
  - From EVALUATE with eval_finished in the same cycle: treated as DONE (swap, valid=1, no overrun).
  - From IDLE or RESTART: render_list_valid<=0, banks unchanged.
  - Next state: RESTART if line_y < ACTIVE_LINES, else IDLE. eval_render_y is updated on the same edge.
- Write routing (registered, 1-cycle latency):
  - hitlist_wr_en <= eval_write_en && state∈{EVALUATE,DONE} && eval_index < HIT_LIST_DEPTH.
  - hitlist_wr_addr <= {write_bank, eval_index[7:0]}.
  - Writes in IDLE or RESTART are suppressed.
  - A write registered on the same edge as a bank swap uses the pre-swap write_bank.
- overrun:
  - Sets on an overrun event.
  - overrun_clear clears it.
  - Set wins over a simultaneous clear.
- Reset mid-evaluation: everything returns to reset values immediately; eval_restart asserts asynchronously.

Decomposition:
- Shared vdp package holds:
  - state encoding (2-bit localparams)
  - HIT_LIST_DEPTH
  - hit-list address width (9)
  - ACTIVE_LINES default
- No sub-module needed. The bank/valid bookkeeping is a few flops inside this block.

Test Plan:
- Reset, then line_start with line_y=10:
  - eval_restart low from T+2, eval_render_y=10.
  - eval_write_en with index 0..2 gives hitlist_wr_addr 0x000..0x002, each 1 cycle later.
- eval_finished, then line_start(line_y=11):
  - render_bank=0, render_list_valid=1, write_bank=1.
  - Next writes land at 0x100+.
- line_start before eval_finished:
  - overrun=1, render_list_valid=0, write_bank unchanged.
  - overrun_clear then drops overrun to 0.
- eval_finished and line_start in the same cycle: swap occurs, overrun stays 0.
- line_y=240:
  - state stays IDLE, eval_restart stays 1.
  - eval_write_en is ignored.
  - The next line_start gives render_list_valid=0.
- eval_index=0x100 with eval_write_en gives no hitlist_wr_en.
- reset_n pulsed low mid-EVALUATE: all outputs take reset values without waiting for a clock edge.
